// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
//   Shared types and sizing for the fetch-to-decode instruction queue.
//   - iq_entry_t  : one queued instruction {pc, inst}
//   - fetch_pkt_t : one fetch packet {mask, pc, inst1, inst0}
//   - popcount2   : number of set bits in a 2-bit slot mask
// -----------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int IQ_DEPTH     = 8;
    localparam int IQ_PTR_WD    = 3;
    localparam int IQ_CNT_WD    = 4;
    localparam int IQ_ENTRY_WD  = 64;
    localparam int FETCH_PKT_WD = 98;

    // Highest occupancy at which a full two-slot packet still fits.
    localparam logic [IQ_CNT_WD-1:0] IQ_READY_MAX = IQ_CNT_WD'(IQ_DEPTH - 2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    typedef struct packed {
        logic [1:0]  mask;
        logic [31:0] pc;
        logic [31:0] inst1;
        logic [31:0] inst0;
    } fetch_pkt_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/iq_slot_compact.sv
// -----------------------------------------------------------------------------
// iq_slot_compact
//   Turns a fetch packet with a per-slot valid mask into 0..2 packed entries,
//   lowest valid slot first, so the queue can write them at consecutive tail
//   positions without caring which slots were valid.
//   Ports:
//     pkt_i  : fetch packet {mask, pc, inst1, inst0}; pc[2:0] is 000
//     ent0_o : first packed entry (meaningful when num_o >= 1)
//     ent1_o : second packed entry (meaningful when num_o == 2)
//     num_o  : number of valid entries (popcount of the mask)
// -----------------------------------------------------------------------------
module iq_slot_compact
    import inst_queue_pkg::*;
(
    input  logic [FETCH_PKT_WD-1:0] pkt_i,
    output iq_entry_t               ent0_o,
    output iq_entry_t               ent1_o,
    output logic [1:0]              num_o
);

    fetch_pkt_t pkt;
    iq_entry_t  slot0;
    iq_entry_t  slot1;

    assign pkt   = fetch_pkt_t'(pkt_i);
    assign slot0 = '{pc: pkt.pc,         inst: pkt.inst0};
    assign slot1 = '{pc: pkt.pc + 32'd4, inst: pkt.inst1};
    assign num_o = popcount2(pkt.mask);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        ent0_o = slot0;
        ent1_o = slot1;
        // A lone slot1 (fetch entered at pc[2]=1) moves down into position 0.
        if (pkt.mask == 2'b10) begin
            ent0_o = slot1;
        end
    end

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   8-entry circular instruction queue between fetch and decode. Fetch pushes
//   up to two instructions per cycle; decode sees the two oldest entries and
//   pops 0..2 per cycle.
//   Ports:
//     clk, resetn            : clock, synchronous active-low reset
//     flush                  : drop all queued and incoming instructions
//     in_valid, in_pc,
//     in_inst0, in_inst1,
//     in_mask                : fetch packet and its per-slot valid mask
//     in_ready               : room for a full two-slot packet
//     out_valid0/1, out_pc0/1,
//     out_inst0/1            : head and head+1 views for decode
//     deq_num                : entries consumed by decode (clamped to valid)
//   Configuration:
//     INST_QUEUE_BYPASS_EN   : when defined, accepted incoming slots appear on
//                              the outputs in the same cycle behind queued
//                              entries; slots consumed that way are not stored.
// -----------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic [1:0]  in_mask,
    output logic        in_ready,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    input  logic [1:0]  deq_num
);

    iq_entry_t              mem_q [IQ_DEPTH];
    logic [IQ_PTR_WD-1:0]   head_q, head_d, head_p1;
    logic [IQ_PTR_WD-1:0]   tail_q, tail_d, tail_p1;
    logic [IQ_CNT_WD-1:0]   count_q, count_d;

    iq_entry_t              ent0, ent1;
    logic [1:0]             inc_num;
    logic                   enq_fire;
    logic [1:0]             enq_num;

    logic [1:0]             q_avail;   // queued entries visible (0..2)
    logic [1:0]             view_num;  // total entries visible (0..2)
    iq_entry_t              view0, view1;
    logic [1:0]             deq_eff;   // clamped dequeue
    logic [1:0]             deq_q;     // part of deq_eff taken from storage
    logic [1:0]             deq_inc;   // part of deq_eff taken from incoming
    logic [1:0]             wr_num;
    iq_entry_t              wr0, wr1;

    // ---------------------------------------------------------------- input
    iq_slot_compact u_compact (
        .pkt_i  ({in_mask, in_pc, in_inst1, in_inst0}),
        .ent0_o (ent0),
        .ent1_o (ent1),
        .num_o  (inc_num)
    );

    assign in_ready = (count_q <= IQ_READY_MAX);
    assign enq_fire = in_valid & in_ready & ~flush;
    assign enq_num  = enq_fire ? inc_num : 2'd0;

    assign head_p1  = head_q + 1'b1;
    assign tail_p1  = tail_q + 1'b1;
    assign q_avail  = (count_q >= 4'd2) ? 2'd2 : count_q[1:0];

    // ----------------------------------------------------------------- view
`ifdef INST_QUEUE_BYPASS_EN
    logic [2:0] view_total;

    always_comb begin
        view_total = {1'b0, q_avail} + {1'b0, enq_num};
        view_num   = (view_total >= 3'd2) ? 2'd2 : view_total[1:0];
        view0      = mem_q[head_q];
        view1      = mem_q[head_p1];
        // Queued entries are older, so incoming slots fill in behind them.
        case (q_avail)
            2'd1: view1 = ent0;
            2'd0: begin
                view0 = ent0;
                view1 = ent1;
            end
            default: ;
        endcase
    end
`else
    assign view_num = q_avail;
    assign view0    = mem_q[head_q];
    assign view1    = mem_q[head_p1];
`endif

    assign out_valid0 = (view_num != 2'd0);
    assign out_valid1 = (view_num == 2'd2);
    assign out_pc0    = view0.pc;
    assign out_inst0  = view0.inst;
    assign out_pc1    = view1.pc;
    assign out_inst1  = view1.inst;

    // -------------------------------------------------------- pop and push
    always_comb begin
        deq_eff = (deq_num > view_num) ? view_num : deq_num;
        deq_q   = (deq_eff > q_avail) ? q_avail : deq_eff;
        // Nonzero only with bypass: those incoming slots never reach storage.
        deq_inc = deq_eff - deq_q;
        wr_num  = enq_num - deq_inc;
        wr0     = (deq_inc == 2'd0) ? ent0 : ent1;
        wr1     = ent1;
    end

    always_comb begin
        head_d  = head_q + IQ_PTR_WD'(deq_q);
        tail_d  = tail_q + IQ_PTR_WD'(wr_num);
        count_d = count_q + IQ_CNT_WD'(wr_num) - IQ_CNT_WD'(deq_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; validity lives entirely in
    // count_q, so clearing the payload would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (resetn && wr_num != 2'd0) begin
            mem_q[tail_q] <= wr0;
        end
        if (resetn && wr_num == 2'd2) begin
            mem_q[tail_p1] <= wr1;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//   Directed bench for inst_queue in its default build (no bypass). Inputs are
//   driven 1 ns after the rising edge and outputs are sampled there, so each
//   check sees the state committed by the preceding edge.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic [1:0]  in_mask;
    logic        in_ready;
    logic        out_valid0;
    logic        out_valid1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [1:0]  deq_num;

    int checks = 0;
    int errors = 0;

    inst_queue dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst0   (in_inst0),
        .in_inst1   (in_inst1),
        .in_mask    (in_mask),
        .in_ready   (in_ready),
        .out_valid0 (out_valid0),
        .out_valid1 (out_valid1),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1),
        .out_inst0  (out_inst0),
        .out_inst1  (out_inst1),
        .deq_num    (deq_num)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] mask,
                         input logic [1:0] deq, input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_mask  = mask;
        in_inst0 = ins(pc);
        in_inst1 = ins(pc + 32'd4);
        deq_num  = deq;
        flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'b00, 2'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset
        resetn = 1'b0;
        idle();
        step();
        step();
        resetn = 1'b1;
        check("rst_valid0", 32'(out_valid0), 32'd0);
        check("rst_valid1", 32'(out_valid1), 32'd0);
        check("rst_ready",  32'(in_ready),   32'd1);

        // ---- first packet, both slots: visible one cycle later
        drive(1'b1, 32'hBFC0_0000, 2'b11, 2'd0, 1'b0);
        in_inst0 = 32'h1111_1111;
        in_inst1 = 32'h2222_2222;
        step();
        idle();
        check("p1_valid0", 32'(out_valid0), 32'd1);
        check("p1_valid1", 32'(out_valid1), 32'd1);
        check("p1_pc0",    out_pc0,   32'hBFC0_0000);
        check("p1_pc1",    out_pc1,   32'hBFC0_0004);
        check("p1_inst0",  out_inst0, 32'h1111_1111);
        check("p1_inst1",  out_inst1, 32'h2222_2222);
        drive(1'b0, 32'h0, 2'b00, 2'd2, 1'b0);
        step();
        idle();
        check("p1_drained", 32'(out_valid0), 32'd0);

        // ---- mask=10: only slot1 enqueued, pc = base+4
        drive(1'b1, 32'hBFC0_0008, 2'b10, 2'd0, 1'b0);
        in_inst0 = 32'hAAAA_AAAA;
        in_inst1 = 32'hBBBB_BBBB;
        step();
        idle();
        check("m10_valid0", 32'(out_valid0), 32'd1);
        check("m10_valid1", 32'(out_valid1), 32'd0);
        check("m10_pc0",    out_pc0,   32'hBFC0_000C);
        check("m10_inst0",  out_inst0, 32'hBBBB_BBBB);

        // ---- deq_num=2 with one valid entry clamps to 1
        drive(1'b0, 32'h0, 2'b00, 2'd2, 1'b0);
        step();
        idle();
        check("clamp_valid0", 32'(out_valid0), 32'd0);
        check("clamp_ready",  32'(in_ready),   32'd1);

        // ---- mask=00 with in_valid enqueues nothing
        drive(1'b1, 32'h0000_0F00, 2'b00, 2'd0, 1'b0);
        step();
        idle();
        check("m00_valid0", 32'(out_valid0), 32'd0);

        // ---- fill to 8 entries, wrapping the tail past 7
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0000_1000 + 32'(8 * k), 2'b11, 2'd0, 1'b0);
            step();
        end
        idle();
        check("full_ready",  32'(in_ready),   32'd0);
        check("full_valid1", 32'(out_valid1), 32'd1);
        check("full_pc0",    out_pc0,   32'h0000_1000);
        check("full_pc1",    out_pc1,   32'h0000_1004);
        check("full_inst1",  out_inst1, ins(32'h0000_1004));

        // fifth packet is refused
        drive(1'b1, 32'h0000_2000, 2'b11, 2'd0, 1'b0);
        step();
        check("fifth_ready", 32'(in_ready), 32'd0);
        check("fifth_pc0",   out_pc0, 32'h0000_1000);

        // full with deq_num=2: in_ready still low this cycle
        drive(1'b1, 32'h0000_2000, 2'b11, 2'd2, 1'b0);
        #1;
        check("fulldeq_ready_same", 32'(in_ready), 32'd0);
        step();
        idle();
        check("fulldeq_ready_next", 32'(in_ready), 32'd1);
        check("fulldeq_pc0",        out_pc0, 32'h0000_1008);
        check("fulldeq_pc1",        out_pc1, 32'h0000_100C);

        // ---- simultaneous enqueue 2 / dequeue 2 at count 6: count stays 6
        drive(1'b1, 32'h0000_3000, 2'b11, 2'd2, 1'b0);
        step();
        idle();
        check("swap_ready", 32'(in_ready), 32'd1);
        check("swap_pc0",   out_pc0, 32'h0000_1010);
        check("swap_pc1",   out_pc1, 32'h0000_1014);

        // drain in order across the head wrap
        drive(1'b0, 32'h0, 2'b00, 2'd2, 1'b0);
        step();
        check("drain1_pc0",   out_pc0,   32'h0000_1018);
        check("drain1_pc1",   out_pc1,   32'h0000_101C);
        check("drain1_inst0", out_inst0, ins(32'h0000_1018));
        step();
        check("drain2_pc0",   out_pc0,   32'h0000_3000);
        check("drain2_pc1",   out_pc1,   32'h0000_3004);
        check("drain2_inst1", out_inst1, ins(32'h0000_3004));
        step();
        idle();
        check("drain3_valid0", 32'(out_valid0), 32'd0);

        // ---- count 7: only one slot of room, in_ready low
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0000_4000 + 32'(8 * k), 2'b11, 2'd0, 1'b0);
            step();
        end
        drive(1'b1, 32'h0000_4018, 2'b01, 2'd0, 1'b0);
        step();
        idle();
        check("c7_ready",  32'(in_ready),   32'd0);
        check("c7_valid1", 32'(out_valid1), 32'd1);
        drive(1'b0, 32'h0, 2'b00, 2'd2, 1'b0);
        step();
        idle();
        check("c5_ready", 32'(in_ready), 32'd1);
        check("c5_pc0",   out_pc0, 32'h0000_4008);

        // ---- flush at count 5 with in_valid and deq_num=2
        drive(1'b1, 32'h0000_6000, 2'b11, 2'd2, 1'b1);
        step();
        idle();
        check("flush_valid0", 32'(out_valid0), 32'd0);
        check("flush_valid1", 32'(out_valid1), 32'd0);
        check("flush_ready",  32'(in_ready),   32'd1);

        // queue works normally after flush
        drive(1'b1, 32'h0000_5000, 2'b11, 2'd0, 1'b0);
        step();
        idle();
        check("pf_pc0",    out_pc0, 32'h0000_5000);
        check("pf_valid1", 32'(out_valid1), 32'd1);
        drive(1'b0, 32'h0, 2'b00, 2'd1, 1'b0);
        step();
        check("pf_deq1_pc0",    out_pc0, 32'h0000_5004);
        check("pf_deq1_valid1", 32'(out_valid1), 32'd0);
        drive(1'b0, 32'h0, 2'b00, 2'd3, 1'b0);
        step();
        idle();
        check("pf_deq3_valid0", 32'(out_valid0), 32'd0);
        check("pf_deq3_ready",  32'(in_ready),   32'd1);

        // ---- reset mid-operation with in_valid asserted
        drive(1'b1, 32'h0000_7000, 2'b11, 2'd0, 1'b0);
        step();
        check("mr_pre_valid0", 32'(out_valid0), 32'd1);
        resetn = 1'b0;
        drive(1'b1, 32'h0000_7008, 2'b11, 2'd0, 1'b0);
        step();
        resetn = 1'b1;
        idle();
        check("mr_valid0", 32'(out_valid0), 32'd0);
        check("mr_ready",  32'(in_ready),   32'd1);
        drive(1'b1, 32'h0000_8000, 2'b01, 2'd0, 1'b0);
        step();
        idle();
        check("mr_post_pc0",    out_pc0, 32'h0000_8000);
        check("mr_post_valid1", 32'(out_valid1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
